// File: rtl/regfile_access_arbiter.sv
// Register-file write-port owner: post-reset clear sweep, then core/debug arbitration
// with bounded debug starvation and single-cycle debug reads through Read1.
module regfile_access_arbiter #(
   parameter int unsigned   NREGS        = 32,
   parameter int unsigned   AW           = 5,
   parameter int unsigned   DW           = 32,
   parameter logic [DW-1:0] INIT_VALUE   = '0,
   parameter int unsigned   STARVE_LIMIT = 4
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic [AW-1:0] core_rs1,
   input  logic          core_wr_valid,
   input  logic [AW-1:0] core_rd,
   input  logic [DW-1:0] core_wdata,
   output logic          core_wr_ready,
   output logic          core_stall,
   input  logic          dbg_req_valid,
   input  logic          dbg_req_write,
   input  logic [AW-1:0] dbg_req_addr,
   input  logic [DW-1:0] dbg_req_wdata,
   output logic          dbg_req_ready,
   output logic          dbg_rsp_valid,
   output logic [DW-1:0] dbg_rsp_rdata,
   output logic [AW-1:0] rf_Read1,
   input  logic [DW-1:0] rf_Data1,
   output logic [AW-1:0] rf_RD,
   output logic [DW-1:0] rf_WriteData,
   output logic          rf_RegWrite,
   output logic          init_done
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] sweep_q, sweep_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          init_done_q, init_done_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q;
   logic          dbg_win;
   logic          core_win;
   logic          wr_en;

   // Next-state and combinational grant; RegWrite is gated by reset_n so nothing commits in reset
   always_comb begin
      state_d       = state_q;
      sweep_d       = sweep_q;
      starve_d      = starve_q;
      init_done_d   = init_done_q;
      rsp_valid_d   = 1'b0;
      dbg_win       = 1'b0;
      core_win      = 1'b0;
      wr_en         = 1'b0;
      core_wr_ready = 1'b0;
      core_stall    = 1'b1;
      dbg_req_ready = 1'b0;
      rf_Read1      = core_rs1;
      rf_RD         = sweep_q;
      rf_WriteData  = INIT_VALUE;

      case (state_q)
         S_INIT: begin
            wr_en   = 1'b1;
            sweep_d = sweep_q + AW'(1);
            if (sweep_q == AW'(NREGS - 1)) begin
               state_d     = S_RUN;
               init_done_d = 1'b1;
            end
         end
         S_RUN: begin
            core_stall   = 1'b0;
            rf_RD        = core_rd;
            rf_WriteData = core_wdata;
            dbg_win      = dbg_req_valid && (!core_wr_valid || starve_q == SW'(STARVE_LIMIT));
            core_win     = core_wr_valid && !dbg_win;
            if (dbg_win) begin
               dbg_req_ready = 1'b1;
               core_stall    = 1'b1;
               starve_d      = '0;
               if (dbg_req_write) begin
                  rf_RD        = dbg_req_addr;
                  rf_WriteData = dbg_req_wdata;
                  wr_en        = (dbg_req_addr != '0);
               end else begin
                  rf_Read1    = dbg_req_addr;
                  rsp_valid_d = 1'b1;
               end
            end else if (core_win) begin
               core_wr_ready = 1'b1;
               wr_en         = (core_rd != '0);
               if (dbg_req_valid && starve_q != SW'(STARVE_LIMIT)) begin
                  starve_d = starve_q + SW'(1);
               end
            end
            if (!dbg_req_valid) begin
               starve_d = '0;
            end
         end
         default: state_d = S_INIT;
      endcase

      rf_RegWrite = wr_en && reset_n;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_INIT;
         sweep_q     <= AW'(1);
         starve_q    <= '0;
         init_done_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         sweep_q     <= sweep_d;
         starve_q    <= starve_d;
         init_done_q <= init_done_d;
         rsp_valid_q <= rsp_valid_d;
         if (rsp_valid_d) begin
            rsp_rdata_q <= rf_Data1;
         end
      end
   end

   assign init_done     = init_done_q;
   assign dbg_rsp_valid = rsp_valid_q;
   assign dbg_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter with a behavioural register file and
// a queue of expected debug read data.
module tb_regfile_access_arbiter;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [4:0]  core_rs1;
   logic        core_wr_valid;
   logic [4:0]  core_rd;
   logic [31:0] core_wdata;
   logic        core_wr_ready;
   logic        core_stall;
   logic        dbg_req_valid;
   logic        dbg_req_write;
   logic [4:0]  dbg_req_addr;
   logic [31:0] dbg_req_wdata;
   logic        dbg_req_ready;
   logic        dbg_rsp_valid;
   logic [31:0] dbg_rsp_rdata;
   logic [4:0]  rf_Read1;
   logic [31:0] rf_Data1;
   logic [4:0]  rf_RD;
   logic [31:0] rf_WriteData;
   logic        rf_RegWrite;
   logic        init_done;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] sb[$];

   // Register file stand-in: stores any commit (x0 included) so an illegal x0 write is visible
   logic [31:0] rf_mem[32];
   bit          filled = 1'b0;
   assign rf_Data1 = rf_mem[rf_Read1];
   always @(posedge clock) begin
      if (!filled) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= (i == 0) ? 32'h0 : (32'hDEAD_0000 | 32'(i));
         filled <= 1'b1;
      end else if (rf_RegWrite) begin
         rf_mem[rf_RD] <= rf_WriteData;
      end
   end

   always #5 clock = ~clock;

   regfile_access_arbiter dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .core_rs1      (core_rs1),
      .core_wr_valid (core_wr_valid),
      .core_rd       (core_rd),
      .core_wdata    (core_wdata),
      .core_wr_ready (core_wr_ready),
      .core_stall    (core_stall),
      .dbg_req_valid (dbg_req_valid),
      .dbg_req_write (dbg_req_write),
      .dbg_req_addr  (dbg_req_addr),
      .dbg_req_wdata (dbg_req_wdata),
      .dbg_req_ready (dbg_req_ready),
      .dbg_rsp_valid (dbg_rsp_valid),
      .dbg_rsp_rdata (dbg_rsp_rdata),
      .rf_Read1      (rf_Read1),
      .rf_Data1      (rf_Data1),
      .rf_RD         (rf_RD),
      .rf_WriteData  (rf_WriteData),
      .rf_RegWrite   (rf_RegWrite),
      .init_done     (init_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_rsp(input bit exp_valid);
      chk("rsp_valid", 32'(dbg_rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL rsp_sb observed=empty_queue expected=pending_entry");
         end else begin
            chk("rsp_rdata", dbg_rsp_rdata, sb.pop_front());
         end
      end
   endtask

   task automatic idle();
      core_wr_valid = 1'b0;
      dbg_req_valid = 1'b0;
      dbg_req_write = 1'b0;
   endtask

   task automatic core_wr(input logic [4:0] rd, input logic [31:0] d);
      core_wr_valid = 1'b1;
      core_rd       = rd;
      core_wdata    = d;
   endtask

   task automatic dbg_rd(input logic [4:0] a, input logic [31:0] exp);
      dbg_req_valid = 1'b1;
      dbg_req_write = 1'b0;
      dbg_req_addr  = a;
      sb.push_back(exp);
   endtask

   task automatic dbg_wr(input logic [4:0] a, input logic [31:0] d);
      dbg_req_valid = 1'b1;
      dbg_req_write = 1'b1;
      dbg_req_addr  = a;
      dbg_req_wdata = d;
   endtask

   initial begin
      reset_n       = 1'b0;
      core_rs1      = '0;
      core_rd       = '0;
      core_wdata    = '0;
      dbg_req_addr  = '0;
      dbg_req_wdata = '0;
      idle();

      // Reset values
      @(negedge clock); #1;
      chk("rst_regwrite", 32'(rf_RegWrite), 32'd0);
      chk("rst_stall", 32'(core_stall), 32'd1);
      chk("rst_wr_ready", 32'(core_wr_ready), 32'd0);
      chk("rst_dbg_ready", 32'(dbg_req_ready), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
      chk("rst_rsp_rdata", dbg_rsp_rdata, 32'd0);

      // Clear sweep with both requesters pending; neither may be acknowledged
      @(negedge clock);
      reset_n = 1'b1;
      core_wr(5'd9, 32'h5555);
      dbg_wr(5'd10, 32'h1);
      #1;
      for (int i = 1; i <= 31; i++) begin
         if (i > 1) begin
            @(negedge clock); #1;
         end
         chk("init_regwrite", 32'(rf_RegWrite), 32'd1);
         chk("init_rd", 32'(rf_RD), 32'(i));
         chk("init_wdata", rf_WriteData, 32'h0);
         chk("init_wr_ready", 32'(core_wr_ready), 32'd0);
         chk("init_dbg_ready", 32'(dbg_req_ready), 32'd0);
         chk("init_done_low", 32'(init_done), 32'd0);
      end
      @(negedge clock); idle(); #1;
      chk("run_init_done", 32'(init_done), 32'd1);
      chk("run_idle_regwrite", 32'(rf_RegWrite), 32'd0);
      chk("run_idle_stall", 32'(core_stall), 32'd0);

      // Core write and readback through Read1
      @(negedge clock); core_wr(5'd3, 32'hABCDEFFF); #1;
      chk("core_wr_ready", 32'(core_wr_ready), 32'd1);
      chk("core_rd", 32'(rf_RD), 32'd3);
      chk("core_regwrite", 32'(rf_RegWrite), 32'd1);
      chk("core_wdata", rf_WriteData, 32'hABCDEFFF);
      @(negedge clock); idle(); core_rs1 = 5'd3; #1;
      chk("core_read1", 32'(rf_Read1), 32'd3);
      chk("core_data1", rf_Data1, 32'hABCDEFFF);

      // Debug reads: latency one, back to back, x0 and a swept register
      @(negedge clock); core_wr(5'd5, 32'hFBCDE111); #1;
      chk("core_wr_ready_x5", 32'(core_wr_ready), 32'd1);
      @(negedge clock); idle(); dbg_rd(5'd5, 32'hFBCDE111); #1;
      chk("dbg_rd_ready", 32'(dbg_req_ready), 32'd1);
      chk("dbg_rd_stall", 32'(core_stall), 32'd1);
      chk("dbg_rd_read1", 32'(rf_Read1), 32'd5);
      chk("dbg_rd_regwrite", 32'(rf_RegWrite), 32'd0);
      chk_rsp(1'b0);
      @(negedge clock); dbg_rd(5'd10, 32'h0); #1;
      chk("dbg_rd_ready_b2b", 32'(dbg_req_ready), 32'd1);
      chk_rsp(1'b1);
      @(negedge clock); dbg_rd(5'd0, 32'h0); #1;
      chk_rsp(1'b1);
      @(negedge clock); dbg_rd(5'd31, 32'h0); #1;
      chk_rsp(1'b1);
      @(negedge clock); idle(); #1;
      chk_rsp(1'b1);
      @(negedge clock); #1;
      chk_rsp(1'b0);

      // Starvation bound: four core grants, then the debug write wins
      @(negedge clock); core_wr(5'd8, 32'h800); dbg_wr(5'd7, 32'h1234); #1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            @(negedge clock); core_wdata = 32'h800 + 32'(k); #1;
         end
         chk("starve_core_ready", 32'(core_wr_ready), 32'd1);
         chk("starve_dbg_ready", 32'(dbg_req_ready), 32'd0);
         chk("starve_core_rd", 32'(rf_RD), 32'd8);
      end
      @(negedge clock); #1;
      chk("starve_dbg_win", 32'(dbg_req_ready), 32'd1);
      chk("starve_stall", 32'(core_stall), 32'd1);
      chk("starve_core_blocked", 32'(core_wr_ready), 32'd0);
      chk("starve_dbg_rd", 32'(rf_RD), 32'd7);
      chk("starve_dbg_wdata", rf_WriteData, 32'h1234);
      chk("starve_dbg_regwrite", 32'(rf_RegWrite), 32'd1);
      @(negedge clock); dbg_req_valid = 1'b0; #1;
      chk("post_dbg_core_ready", 32'(core_wr_ready), 32'd1);
      @(negedge clock); idle(); dbg_rd(5'd7, 32'h1234); #1;
      chk("x7_rd_ready", 32'(dbg_req_ready), 32'd1);
      @(negedge clock); idle(); dbg_rd(5'd8, 32'h803); #1;
      chk_rsp(1'b1);
      @(negedge clock); idle(); #1;
      chk_rsp(1'b1);

      // x0 writes are acknowledged but never committed
      @(negedge clock); core_wr(5'd0, 32'hFFFFFFFF); #1;
      chk("x0_core_ready", 32'(core_wr_ready), 32'd1);
      chk("x0_core_regwrite", 32'(rf_RegWrite), 32'd0);
      @(negedge clock); idle(); dbg_wr(5'd0, 32'h1); #1;
      chk("x0_dbg_ready", 32'(dbg_req_ready), 32'd1);
      chk("x0_dbg_regwrite", 32'(rf_RegWrite), 32'd0);
      @(negedge clock); idle(); dbg_rd(5'd0, 32'h0); #1;
      @(negedge clock); idle(); #1;
      chk_rsp(1'b1);

      // Reset while a read response is pending
      @(negedge clock); dbg_rd(5'd3, 32'hABCDEFFF); #1;
      chk("rr_dbg_ready", 32'(dbg_req_ready), 32'd1);
      @(negedge clock); idle(); #1;
      chk_rsp(1'b1);
      reset_n = 1'b0;
      #1;
      chk("rr_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
      chk("rr_init_done", 32'(init_done), 32'd0);
      chk("rr_regwrite", 32'(rf_RegWrite), 32'd0);
      chk("rr_stall", 32'(core_stall), 32'd1);
      sb.delete();
      @(negedge clock);
      @(negedge clock); reset_n = 1'b1; #1;
      chk("rr_sweep_rd1", 32'(rf_RD), 32'd1);
      chk("rr_sweep_regwrite", 32'(rf_RegWrite), 32'd1);
      @(negedge clock); #1;
      chk("rr_sweep_rd2", 32'(rf_RD), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
